// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S constants, channel type and clog2 helper
// Used by the receiver, and intended for i2s_controller and the transmitters.
package i2s_pkg;

    localparam int MODE_I2S = 0;    // Philips I2S: MSB one sck after the ws edge
    localparam int MODE_LJ  = 1;    // left-justified: MSB on the ws edge

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_channel_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/i2s_stream_receiver_if.sv
// rtl/i2s_stream_receiver_if.sv - valid/ready stream bundle for FIFO head entries
// Signals: valid (entry present), ready (consumer takes it), data (entry payload).
// master: the producer (FIFO read side); slave: the consumer.
interface i2s_stream_receiver_if #(
    parameter int WIDTH = 48
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/i2s_pair_fifo.sv
// rtl/i2s_pair_fifo.sv - stereo-pair FIFO with drop-on-full and registered head
// Ports: clk, reset (async, active-high), push/push_data (write side),
//        rd (stream master: head entry, valid, ready), level (occupancy),
//        drop (pulse: push refused because full with no simultaneous pop).
module i2s_pair_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    i2s_stream_receiver_if.master   rd,
    output logic [clog2(DEPTH):0]   level,
    output logic                    drop
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop;
    logic             full;
    logic             do_push;

    assign pop     = rd.valid & rd.ready;
    assign full    = (count == FULL_LEVEL);
    // A pop in the same cycle frees the slot, so full only blocks a lone push.
    assign do_push = push & (~full | pop);
    assign drop    = push & full & ~pop;

    assign rd.valid = (count != '0);
    assign rd.data  = mem[rd_ptr];
    assign level    = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/i2s_stream_receiver.sv
// rtl/i2s_stream_receiver.sv - I2S / left-justified serial receiver with stereo-pair FIFO
// Ports: clk, reset (async, active-high); sck/ws/sd serial input (sck synchronous to clk);
//        m_valid/m_ready/m_left/m_right pair stream; level (FIFO occupancy);
//        overflow (sticky, pair dropped) with overflow_clr (synchronous clear).
module i2s_stream_receiver
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MODE       = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sck,
    input  logic                        ws,
    input  logic                        sd,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH-1:0]       m_left,
    output logic [DATA_WIDTH-1:0]       m_right,
    output logic [clog2(FIFO_DEPTH):0]  level,
    output logic                        overflow,
    input  logic                        overflow_clr
);

    localparam int PW    = clog2(SLOT_WIDTH + 1);
    localparam int DELAY = (MODE == MODE_I2S) ? 1 : 0;
    localparam logic [PW-1:0] POS_MAX   = PW'(SLOT_WIDTH);
    localparam logic [PW-1:0] POS_FIRST = PW'(DELAY);
    localparam logic [PW-1:0] POS_LAST  = PW'(DELAY + DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MSB_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic                  sck_q;
    logic                  ws_prev;     // ws at the previous sck rise
    logic                  ws_seen;     // ws_prev holds a real sample
    logic                  in_slot;     // a ws transition has been seen since reset
    i2s_channel_e          ch;
    logic [PW-1:0]         pos;         // rises since slot start, saturating
    logic                  done;        // current slot word already complete
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] left_word;
    logic                  left_ok;     // left word of this frame is complete

    logic                  rise;
    logic                  slot_start;
    logic [PW-1:0]         cur_pos;
    logic                  cur_done;
    logic                  cap_en;
    logic                  fin_cap;
    logic                  fin_prev;
    logic [DATA_WIDTH-1:0] cap_word;
    logic [DATA_WIDTH-1:0] fin_word;
    logic                  push;
    logic                  drop;

    always_comb begin
        rise       = sck & ~sck_q;
        slot_start = rise & ws_seen & (ws != ws_prev);
        if (slot_start) begin
            cur_pos = '0;
        end else if (pos == POS_MAX) begin
            cur_pos = POS_MAX;
        end else begin
            cur_pos = pos + 1'b1;
        end
        cur_done = slot_start ? 1'b0 : done;
        cap_en   = rise & (slot_start | in_slot) & ~cur_done
                 & (DELAY == 0 || cur_pos != '0) & (cur_pos <= POS_LAST);
        // Bits are OR-ed into a word cleared at slot start, so any bits not
        // reached before the next slot start stay zero.
        cap_word = slot_start ? '0 : shreg;
        if (cap_en && sd) begin
            cap_word = cap_word | (MSB_MASK >> (cur_pos - POS_FIRST));
        end
        fin_cap  = cap_en & (cur_pos == POS_LAST);
        // Short slot: the previous word is closed out by the new slot start.
        fin_prev = slot_start & in_slot & ~done;
        fin_word = fin_prev ? shreg : cap_word;
        // fin_cap can never coincide with a slot start, so ch is the channel
        // of the finishing word in both cases.
        push     = (fin_cap | fin_prev) & (ch == CH_RIGHT) & left_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_q     <= 1'b0;
            ws_prev   <= 1'b0;
            ws_seen   <= 1'b0;
            in_slot   <= 1'b0;
            ch        <= CH_LEFT;
            pos       <= '0;
            done      <= 1'b0;
            shreg     <= '0;
            left_word <= '0;
            left_ok   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sck_q <= sck;
            if (rise) begin
                ws_seen <= 1'b1;
                ws_prev <= ws;
                pos     <= cur_pos;
                done    <= cur_done | fin_cap;
                shreg   <= cap_word;
                if (slot_start) begin
                    in_slot <= 1'b1;
                    ch      <= i2s_channel_e'(ws);
                end
            end
            if (slot_start && !ws) begin
                left_ok <= 1'b0;
            end
            if ((fin_cap || fin_prev) && ch == CH_LEFT) begin
                left_word <= fin_word;
                left_ok   <= 1'b1;
            end else if ((fin_cap || fin_prev) && ch == CH_RIGHT) begin
                left_ok   <= 1'b0;
            end
            // A drop wins over a clear in the same cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    i2s_stream_receiver_if #(.WIDTH(2 * DATA_WIDTH)) head_if ();

    assign head_if.ready = m_ready;
    assign m_valid       = head_if.valid;
    assign m_left        = head_if.data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign m_right       = head_if.data[DATA_WIDTH-1:0];

    i2s_pair_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({left_word, fin_word}),
        .rd        (head_if.master),
        .level     (level),
        .drop      (drop)
    );

endmodule

// File: tb/tb_i2s_stream_receiver.sv
// tb/tb_i2s_stream_receiver.sv - scoreboard bench for i2s_stream_receiver (I2S and LJ instances)
module tb_i2s_stream_receiver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sck = 1'b0;
    logic ws = 1'b1;
    logic sd = 1'b0;
    logic ovf_clr = 1'b0;
    logic rdy_base = 1'b0;
    logic pulse0 = 1'b0;
    logic pulse1 = 1'b0;

    logic [23:0] left0, right0, left1, right1;
    logic [2:0]  level0, level1;
    logic        ovf0, ovf1;

    int checks = 0;
    int failures = 0;

    logic [47:0] q0[$];
    logic [47:0] q1[$];

    // Frame table: I2S stream values and the left-justified decoding of them.
    logic [23:0] tab_l  [5] = '{24'h111111, 24'h333333, 24'h555555, 24'h777777, 24'h999999};
    logic [23:0] tab_r  [5] = '{24'h222222, 24'h444444, 24'h666666, 24'h888888, 24'hAAAAAA};
    logic [23:0] tab_l1 [5] = '{24'h088888, 24'h199999, 24'h2AAAAA, 24'h3BBBBB, 24'h4CCCCC};
    logic [23:0] tab_r1 [5] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555};

    i2s_stream_receiver_if #(.WIDTH(48)) mon0 ();
    i2s_stream_receiver_if #(.WIDTH(48)) mon1 ();

    assign mon0.ready = rdy_base | pulse0;
    assign mon1.ready = rdy_base | pulse1;
    assign mon0.data  = {left0, right0};
    assign mon1.data  = {left1, right1};

    always #5 clk = ~clk;

    i2s_stream_receiver #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .FIFO_DEPTH(4), .MODE(0)) dut0 (
        .clk(clk), .reset(reset), .sck(sck), .ws(ws), .sd(sd),
        .m_valid(mon0.valid), .m_ready(mon0.ready), .m_left(left0), .m_right(right0),
        .level(level0), .overflow(ovf0), .overflow_clr(ovf_clr)
    );

    i2s_stream_receiver #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .FIFO_DEPTH(4), .MODE(1)) dut1 (
        .clk(clk), .reset(reset), .sck(sck), .ws(ws), .sd(sd),
        .m_valid(mon1.valid), .m_ready(mon1.ready), .m_left(left1), .m_right(right1),
        .level(level1), .overflow(ovf1), .overflow_clr(ovf_clr)
    );

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && mon0.valid && mon0.ready) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop0_unexpected actual=%h expected=none", mon0.data);
            end else begin
                chk("pop0", mon0.data, q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && mon1.valid && mon1.ready) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop1_unexpected actual=%h expected=none", mon1.data);
            end else begin
                chk("pop1", mon1.data, q1.pop_front());
            end
        end
    end

    task automatic expect_pair(input logic [47:0] e0, input logic [47:0] e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    // One sck period: 2 clk low then 2 clk high; a ready pulse covers the rise edge.
    task automatic send_bit(input logic w, input logic d, input logic p0, input logic p1);
        @(posedge clk); #1; sck = 1'b0; ws = w; sd = d;
        @(posedge clk); #1;
        @(posedge clk); #1; sck = 1'b1; pulse0 = p0; pulse1 = p1;
        @(posedge clk); #1; pulse0 = 1'b0; pulse1 = 1'b0;
    endtask

    task automatic i2s_slot(input logic w, input logic [23:0] word, input int k_lo, input int k_hi,
                            input int nbits, input int p0k, input int p1k);
        for (int k = k_lo; k <= k_hi; k++) begin
            logic b;
            b = 1'b0;
            if (k >= 1 && k <= nbits) b = word[24-k];
            send_bit(w, b, k == p0k, k == p1k);
        end
    endtask

    task automatic i2s_frame(input logic [23:0] l, input logic [23:0] r, input int lbits,
                             input int p0k, input int p1k);
        i2s_slot(1'b0, l, 0, (lbits < 24) ? lbits : 31, lbits, -1, -1);
        i2s_slot(1'b1, r, 0, 31, 24, p0k, p1k);
    endtask

    task automatic lj_frame(input logic [23:0] l, input logic [23:0] r);
        for (int k = 0; k < 32; k++) begin
            logic b;
            b = 1'b0;
            if (k < 24) b = l[23-k];
            send_bit(1'b0, b, 1'b0, 1'b0);
        end
        for (int k = 0; k < 32; k++) begin
            logic b;
            b = 1'b0;
            if (k < 24) b = r[23-k];
            send_bit(1'b1, b, 1'b0, 1'b0);
        end
    endtask

    task automatic drain();
        rdy_base = 1'b1;
        for (int n = 0; n < 200 && (q0.size() != 0 || q1.size() != 0); n++) begin
            @(posedge clk);
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d/%0d pending expected=0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        @(posedge clk); #1;
        rdy_base = 1'b0;
        @(posedge clk); #1;
        chk("drain_level0", 48'(level0), 48'd0);
        chk("drain_level1", 48'(level1), 48'd0);
    endtask

    initial begin
        #500000;
        checks++;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (4) @(posedge clk);
        #1;
        chk("rst_valid0", 48'(mon0.valid), 48'd0);
        chk("rst_level0", 48'(level0), 48'd0);
        chk("rst_ovf0", 48'(ovf0), 48'd0);
        chk("rst_data0", mon0.data, 48'd0);
        chk("rst_valid1", 48'(mon1.valid), 48'd0);
        chk("rst_level1", 48'(level1), 48'd0);
        reset = 1'b0;

        // Idle right-channel bits: ws history builds but nothing is captured.
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1, 1'b0, 1'b0);

        // I2S frame; the LJ instance sees every word shifted right by one.
        i2s_frame(24'hAAAAAA, 24'h555555, 24, -1, -1);
        expect_pair({24'hAAAAAA, 24'h555555}, {24'h555555, 24'h2AAAAA});
        chk("basic_level0", 48'(level0), 48'd1);
        chk("basic_level1", 48'(level1), 48'd1);
        drain();

        // Left-justified frame; the I2S instance sees every word shifted left by one.
        lj_frame(24'h123456, 24'hABCDEF);
        expect_pair({24'h2468AC, 24'h579BDE}, {24'h123456, 24'hABCDEF});
        drain();

        // Five frames with no consumer: fifth pair is dropped.
        for (int f = 0; f < 5; f++) begin
            i2s_frame(tab_l[f], tab_r[f], 24, -1, -1);
            if (f < 4) expect_pair({tab_l[f], tab_r[f]}, {tab_l1[f], tab_r1[f]});
        end
        chk("ovf_level0", 48'(level0), 48'd4);
        chk("ovf_level1", 48'(level1), 48'd4);
        chk("ovf_set0", 48'(ovf0), 48'd1);
        chk("ovf_set1", 48'(ovf1), 48'd1);
        @(posedge clk); #1; ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        chk("ovf_clr0", 48'(ovf0), 48'd0);
        chk("ovf_clr1", 48'(ovf1), 48'd0);
        drain();

        // Fill, then pop exactly on the edge where the fifth pair completes.
        for (int f = 0; f < 5; f++) begin
            if (f < 4) i2s_frame(tab_l[f], tab_r[f], 24, -1, -1);
            else       i2s_frame(tab_l[f], tab_r[f], 24, 24, 23);
            expect_pair({tab_l[f], tab_r[f]}, {tab_l1[f], tab_r1[f]});
        end
        chk("fullpp_level0", 48'(level0), 48'd4);
        chk("fullpp_level1", 48'(level1), 48'd4);
        chk("fullpp_ovf0", 48'(ovf0), 48'd0);
        chk("fullpp_ovf1", 48'(ovf1), 48'd0);
        drain();

        // Reset at bit 10 of a left slot with one pair already buffered.
        i2s_frame(24'h13579B, 24'h2468AC, 24, -1, -1);
        chk("prerst_level0", 48'(level0), 48'd1);
        i2s_slot(1'b0, 24'h5A5A5A, 0, 10, 24, -1, -1);
        @(posedge clk); #1; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_level0", 48'(level0), 48'd0);
        chk("midrst_valid0", 48'(mon0.valid), 48'd0);
        chk("midrst_level1", 48'(level1), 48'd0);
        chk("midrst_valid1", 48'(mon1.valid), 48'd0);
        chk("midrst_data0", mon0.data, 48'd0);
        q0.delete();
        q1.delete();
        reset = 1'b0;
        i2s_slot(1'b0, 24'h5A5A5A, 11, 31, 24, -1, -1);
        i2s_slot(1'b1, 24'hC3C3C3, 0, 31, 24, -1, -1);
        chk("partial_level0", 48'(level0), 48'd0);
        chk("partial_level1", 48'(level1), 48'd0);
        i2s_frame(24'hC0FFEE, 24'h0BADF0, 24, -1, -1);
        expect_pair({24'hC0FFEE, 24'h0BADF0}, {24'h607FF7, 24'h05D6F8});
        drain();

        // Short left slot of 16 data bits: missing LSBs are zero.
        i2s_frame(24'hFFFF00, 24'h000F0F, 16, -1, -1);
        expect_pair({24'hFFFF00, 24'h000F0F}, {24'h7FFF80, 24'h000787});
        drain();

        chk("end_ovf0", 48'(ovf0), 48'd0);
        chk("end_ovf1", 48'(ovf1), 48'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
